prog_loader: RTL and testbench

- Writer side of the instruction-memory interface. Receives a program as a byte stream over a valid/ready handshake and packs each 4 bytes, little-endian, into a 32-bit word.
- Writes each word into the 64-word instruction memory, which the CPU fetches with addr = pc[7:2].
- Holds the CPU in reset while loading, then releases it so the CPU starts fetching from address 0.
- Sits between the host/UART byte source, the instruction memory write port and the CPU resetn input.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader_byte_packer.sv | 54 +++++
 rtl/prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the program loader and the CPU instruction memory:
// loader FSM state encoding, instruction-memory geometry and the default
// CPU reset hold time after a load.
package prog_loader_pkg;

   localparam int IMEM_ADDR_W        = 6;
   localparam int IMEM_WORDS         = 64;
   localparam int RESET_HOLD_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
// Groups the byte-stream handshake and the instruction-memory write port.
//   byte_valid / byte_data : byte source -> loader
//   byte_ready             : loader -> byte source
//   imem_wen / imem_waddr / imem_wdata : loader -> instruction memory
// master: the loader side.  slave: the byte source / memory side.
interface prog_loader_if;
   import prog_loader_pkg::*;

   logic                   byte_valid;
   logic [7:0]             byte_data;
   logic                   byte_ready;
   logic                   imem_wen;
   logic [IMEM_ADDR_W-1:0] imem_waddr;
   logic [31:0]            imem_wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, imem_wen, imem_waddr, imem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, imem_wen, imem_waddr, imem_wdata
   );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer
// Collects four accepted bytes into a little-endian 32-bit word.
//   clk, resetn  : clock, synchronous active-low reset
//   accept_i     : a byte is consumed this cycle
//   byte_i       : the byte being consumed
//   clear_i      : restart at byte lane 0
//   word_o       : stored lanes with the current byte already merged in
//   word_full_o  : this cycle's accepted byte completes the word
// word_o/word_full_o look through to the incoming byte so the owner can
// register the finished word on the same edge that accepts its last byte.
module byte_packer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   input  logic        clear_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] lanes_q, lanes_d;

   // Merge the incoming byte into its lane and advance the lane index.
   always_comb begin
      word_o      = lanes_q;
      word_full_o = 1'b0;
      lanes_d     = lanes_q;
      idx_d       = idx_q;
      if (accept_i) begin
         word_o[idx_q*8 +: 8] = byte_i;
         word_full_o          = (idx_q == 2'd3);
      end
      if (clear_i) begin
         lanes_d = '0;
         idx_d   = '0;
      end else if (accept_i) begin
         lanes_d = word_o;
         idx_d   = idx_q + 2'd1;
      end
   end

   // Lane storage and index.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         idx_q   <= '0;
         lanes_q <= '0;
      end else begin
         idx_q   <= idx_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Loads a program from a byte stream into the 64-word instruction memory,
// holding the CPU in reset during the load and for RESET_HOLD cycles after.
//   clk, resetn    : clock, synchronous active-low reset
//   load_start_i   : start a load (sampled in IDLE only)
//   word_count_i   : words to load, legal 1..MAX_WORDS
//   bus            : byte stream in, instruction-memory write port out
//   cpu_resetn_o   : active-low CPU reset
//   busy_o         : load in progress
//   done_o         : one-cycle pulse at load completion
//   err_o          : one-cycle pulse on an illegal word count
//   checksum_o     : XOR of all words written in the current/last load
// All outputs are registered.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W     = IMEM_ADDR_W,
   parameter int MAX_WORDS  = IMEM_WORDS,
   parameter int RESET_HOLD = RESET_HOLD_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load_start_i,
   input  logic [6:0]        word_count_i,
   prog_loader_if.master     bus,
   output logic              cpu_resetn_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [31:0]       checksum_o
);

   state_t              state_q, state_d;
   logic [6:0]          count_q, count_d;
   logic [6:0]          word_idx_q, word_idx_d;
   logic [7:0]          hold_cnt_q, hold_cnt_d;
   logic                byte_ready_q, byte_ready_d;
   logic                imem_wen_q, imem_wen_d;
   logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
   logic [31:0]         imem_wdata_q, imem_wdata_d;
   logic                cpu_resetn_q, cpu_resetn_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [31:0]         checksum_q, checksum_d;

   logic                accept;
   logic                pack_clear;
   logic [31:0]         pack_word;
   logic                pack_full;
   logic                count_ok;

   // byte_ready_q is only ever high in RECV, so it alone qualifies a handshake.
   assign accept   = bus.byte_valid & byte_ready_q;
   assign count_ok = (word_count_i != 7'd0) && (word_count_i <= 7'(MAX_WORDS));

   byte_packer u_packer (
      .clk         (clk),
      .resetn      (resetn),
      .accept_i    (accept),
      .byte_i      (bus.byte_data),
      .clear_i     (pack_clear),
      .word_o      (pack_word),
      .word_full_o (pack_full)
   );

   // Next-state and next-output logic; every output is computed one cycle
   // ahead so that it appears registered together with the state it belongs to.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      word_idx_d   = word_idx_q;
      hold_cnt_d   = hold_cnt_q;
      byte_ready_d = byte_ready_q;
      imem_wen_d   = 1'b0;
      imem_waddr_d = imem_waddr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_resetn_d = cpu_resetn_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      checksum_d   = checksum_q;
      pack_clear   = 1'b0;

      case (state_q)
         IDLE: begin
            cpu_resetn_d = 1'b1;
            byte_ready_d = 1'b0;
            busy_d       = 1'b0;
            if (load_start_i) begin
               if (count_ok) begin
                  count_d      = word_count_i;
                  checksum_d   = '0;
                  word_idx_d   = '0;
                  pack_clear   = 1'b1;
                  busy_d       = 1'b1;
                  cpu_resetn_d = 1'b0;
                  byte_ready_d = 1'b1;
                  state_d      = RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         RECV: begin
            if (pack_full) begin
               byte_ready_d = 1'b0;
               imem_wen_d   = 1'b1;
               imem_waddr_d = word_idx_q[ADDR_W-1:0];
               imem_wdata_d = pack_word;
               checksum_d   = checksum_q ^ pack_word;
               state_d      = WRITE;
            end
         end

         WRITE: begin
            if (word_idx_q == count_q - 7'd1) begin
               hold_cnt_d = 8'(RESET_HOLD - 1);
               state_d    = HOLD;
            end else begin
               word_idx_d   = word_idx_q + 7'd1;
               pack_clear   = 1'b1;
               byte_ready_d = 1'b1;
               state_d      = RECV;
            end
         end

         HOLD: begin
            if (hold_cnt_q == 8'd0) begin
               done_d       = 1'b1;
               busy_d       = 1'b0;
               cpu_resetn_d = 1'b1;
               state_d      = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         count_q      <= '0;
         word_idx_q   <= '0;
         hold_cnt_q   <= '0;
         byte_ready_q <= 1'b0;
         imem_wen_q   <= 1'b0;
         imem_waddr_q <= '0;
         imem_wdata_q <= '0;
         cpu_resetn_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         checksum_q   <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         word_idx_q   <= word_idx_d;
         hold_cnt_q   <= hold_cnt_d;
         byte_ready_q <= byte_ready_d;
         imem_wen_q   <= imem_wen_d;
         imem_waddr_q <= imem_waddr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_resetn_q <= cpu_resetn_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         checksum_q   <= checksum_d;
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.imem_wen   = imem_wen_q;
   assign bus.imem_waddr = imem_waddr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign cpu_resetn_o   = cpu_resetn_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign checksum_o     = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed bench for prog_loader. Expected memory writes are queued when a
// load is driven and checked in order by a write monitor.
module tb_prog_loader;
   import prog_loader_pkg::*;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        resetn;
   logic        load_start;
   logic [6:0]  word_count;
   logic        cpu_resetn;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] checksum;

   int   total = 0;
   int   bad   = 0;
   int   wrCount = 0;
   int   doneCount = 0;
   logic [5:0] lastAddr = '0;
   wr_t  sbq[$];

   prog_loader_if bus ();

   prog_loader dut (
      .clk          (clk),
      .resetn       (resetn),
      .load_start_i (load_start),
      .word_count_i (word_count),
      .bus          (bus),
      .cpu_resetn_o (cpu_resetn),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .checksum_o   (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write monitor: every write must match the head of the scoreboard.
   always @(posedge clk) begin
      #1;
      if (bus.imem_wen === 1'b1) begin
         wrCount++;
         lastAddr = bus.imem_waddr;
         checkOutput("wr_ready_low", {31'd0, bus.byte_ready}, 32'd0);
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL wr_unexpected observed addr=%0d data=%h expected no write",
                   bus.imem_waddr, bus.imem_wdata);
         end else begin
            wr_t e;
            e = sbq.pop_front();
            checkOutput("wr_addr", {26'd0, bus.imem_waddr}, {26'd0, e.addr});
            checkOutput("wr_data", bus.imem_wdata, e.data);
         end
      end
      if (done === 1'b1) doneCount++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic ls, input logic [6:0] cnt);
      load_start = ls;
      word_count = cnt;
      step();
      load_start = 1'b0;
   endtask

   task automatic startLoad(input logic [6:0] cnt);
      applyStimulus(1'b1, cnt);
      checkOutput("start_busy", {31'd0, busy}, 32'd1);
      checkOutput("start_cpurst", {31'd0, cpu_resetn}, 32'd0);
      checkOutput("start_ready", {31'd0, bus.byte_ready}, 32'd1);
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      while (bus.byte_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("byte_ready_timeout", {31'd0, bus.byte_ready}, 32'd1);
      step();
      bus.byte_valid = 1'b0;
      repeat (gap) step();
   endtask

   task automatic sendWord(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) sendByte(w[i*8 +: 8], gap);
   endtask

   task automatic pushWr(input logic [5:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sbq.push_back(e);
   endtask

   task automatic waitDone(input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         step();
         n++;
      end
      checkOutput(tag, {31'd0, done}, 32'd1);
      checkOutput("done_busy", {31'd0, busy}, 32'd0);
      checkOutput("done_cpurst", {31'd0, cpu_resetn}, 32'd1);
      step();
      checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int w0, d0;
      logic [31:0] wa, wb;
      resetn         = 1'b0;
      load_start     = 1'b0;
      word_count     = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      repeat (3) step();

      // Reset state
      checkOutput("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
      checkOutput("rst_wen", {31'd0, bus.imem_wen}, 32'd0);
      checkOutput("rst_cpurst", {31'd0, cpu_resetn}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_checksum", checksum, 32'd0);
      resetn = 1'b1;
      step();
      checkOutput("rel_cpurst", {31'd0, cpu_resetn}, 32'd1);

      // Single word, back-to-back bytes, exact latency and hold length
      startLoad(7'd1);
      pushWr(6'd0, 32'h12345678);
      sendByte(8'h78, 0);
      sendByte(8'h56, 0);
      sendByte(8'h34, 0);
      sendByte(8'h12, 0);
      checkOutput("t1_wen", {31'd0, bus.imem_wen}, 32'd1);
      checkOutput("t1_addr", {26'd0, bus.imem_waddr}, 32'd0);
      checkOutput("t1_data", bus.imem_wdata, 32'h12345678);
      checkOutput("t1_checksum", checksum, 32'h12345678);
      checkOutput("t1_cpurst_write", {31'd0, cpu_resetn}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("t1_hold_cpurst", {31'd0, cpu_resetn}, 32'd0);
         checkOutput("t1_hold_done", {31'd0, done}, 32'd0);
      end
      step();
      checkOutput("t1_done", {31'd0, done}, 32'd1);
      checkOutput("t1_busy", {31'd0, busy}, 32'd0);
      checkOutput("t1_cpurst_after", {31'd0, cpu_resetn}, 32'd1);
      step();
      checkOutput("t1_done_end", {31'd0, done}, 32'd0);

      // Three words, throttled 1-in-3
      w0 = wrCount;
      startLoad(7'd3);
      pushWr(6'd0, 32'h00000001);
      pushWr(6'd1, 32'h00000010);
      pushWr(6'd2, 32'h00000100);
      sendWord(32'h00000001, 2);
      sendWord(32'h00000010, 2);
      sendWord(32'h00000100, 2);
      waitDone("t2_done");
      checkOutput("t2_checksum", checksum, 32'h00000111);
      checkOutput("t2_writes", 32'(wrCount - w0), 32'd3);

      // Illegal counts
      w0 = wrCount;
      applyStimulus(1'b1, 7'd0);
      checkOutput("t3_err0", {31'd0, err}, 32'd1);
      checkOutput("t3_busy0", {31'd0, busy}, 32'd0);
      checkOutput("t3_cpurst0", {31'd0, cpu_resetn}, 32'd1);
      step();
      checkOutput("t3_err0_end", {31'd0, err}, 32'd0);
      applyStimulus(1'b1, 7'd65);
      checkOutput("t3_err65", {31'd0, err}, 32'd1);
      checkOutput("t3_busy65", {31'd0, busy}, 32'd0);
      checkOutput("t3_cpurst65", {31'd0, cpu_resetn}, 32'd1);
      step();
      checkOutput("t3_err65_end", {31'd0, err}, 32'd0);
      repeat (3) step();
      checkOutput("t3_writes", 32'(wrCount - w0), 32'd0);

      // Full 64-word program, word i = i
      w0 = wrCount;
      startLoad(7'd64);
      for (int i = 0; i < 64; i++) pushWr(6'(i), 32'(i));
      for (int i = 0; i < 64; i++) sendWord(32'(i), 0);
      waitDone("t4_done");
      checkOutput("t4_checksum", checksum, 32'd0);
      checkOutput("t4_writes", 32'(wrCount - w0), 32'd64);
      checkOutput("t4_last_addr", {26'd0, lastAddr}, 32'd63);
      checkOutput("t4_sb_empty", 32'(sbq.size()), 32'd0);

      // Abort mid-load with reset
      w0 = wrCount;
      startLoad(7'd2);
      pushWr(6'd0, 32'hA1B2C3D4);
      sendWord(32'hA1B2C3D4, 0);
      sendByte(8'h11, 0);
      sendByte(8'h22, 0);
      resetn = 1'b0;
      step();
      checkOutput("t5_ready", {31'd0, bus.byte_ready}, 32'd0);
      checkOutput("t5_wen", {31'd0, bus.imem_wen}, 32'd0);
      checkOutput("t5_waddr", {26'd0, bus.imem_waddr}, 32'd0);
      checkOutput("t5_wdata", bus.imem_wdata, 32'd0);
      checkOutput("t5_cpurst", {31'd0, cpu_resetn}, 32'd0);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_done", {31'd0, done}, 32'd0);
      checkOutput("t5_err", {31'd0, err}, 32'd0);
      checkOutput("t5_checksum", checksum, 32'd0);
      resetn = 1'b1;
      step();
      checkOutput("t5_cpurst_rel", {31'd0, cpu_resetn}, 32'd1);
      checkOutput("t5_writes", 32'(wrCount - w0), 32'd1);
      startLoad(7'd1);
      pushWr(6'd0, 32'hCAFEF00D);
      sendWord(32'hCAFEF00D, 1);
      waitDone("t5_reload_done");
      checkOutput("t5_reload_checksum", checksum, 32'hCAFEF00D);

      // load_start during RECV is ignored
      w0 = wrCount;
      d0 = doneCount;
      wa = 32'h0BADF00D;
      wb = 32'h5EED1234;
      startLoad(7'd2);
      pushWr(6'd0, wa);
      pushWr(6'd1, wb);
      sendByte(wa[7:0], 0);
      applyStimulus(1'b1, 7'd5);
      checkOutput("t6_no_err", {31'd0, err}, 32'd0);
      checkOutput("t6_busy", {31'd0, busy}, 32'd1);
      sendByte(wa[15:8], 0);
      sendByte(wa[23:16], 0);
      sendByte(wa[31:24], 0);
      sendWord(wb, 1);
      waitDone("t6_done");
      repeat (10) step();
      checkOutput("t6_done_once", 32'(doneCount - d0), 32'd1);
      checkOutput("t6_writes", 32'(wrCount - w0), 32'd2);
      checkOutput("t6_checksum", checksum, wa ^ wb);
      checkOutput("final_sb_empty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
